// File: rtl/move_buffer_writer.sv
// Producer side of the toggle-latch move buffer: stores move commands in a slot ring
// and publishes each slot to the DDA timer by toggling its stepready bit.
module move_buffer_writer #(
    parameter int DEPTH    = 4,
    parameter int IDX_BITS = 2
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                halt,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [63:0]         cmd_duration,
    input  logic [63:0]         cmd_increment,
    input  logic [63:0]         cmd_incrementincrement,
    output logic [DEPTH-1:0]    stepready,
    input  logic [DEPTH-1:0]    stepfinished,
    output logic [IDX_BITS-1:0] writemoveind,
    input  logic [IDX_BITS-1:0] moveind,
    output logic [63:0]         move_duration,
    output logic [63:0]         increment,
    output logic [63:0]         incrementincrement,
    output logic                buffer_full,
    output logic                buffer_empty,
    output logic [31:0]         move_count
);

    typedef enum logic {ACCEPT, COMMIT} state_t;

    state_t state, next_state;

    logic [63:0] slot_duration [DEPTH];
    logic [63:0] slot_increment [DEPTH];
    logic [63:0] slot_incinc [DEPTH];

    logic [DEPTH-1:0] occ;
    logic             accept;
    logic             commit;

    assign occ          = stepready ^ stepfinished;
    assign buffer_full  = occ[writemoveind];
    assign buffer_empty = ~|occ;
    assign accept       = (state == ACCEPT) && cmd_valid && cmd_ready;
    assign commit       = (state == COMMIT) && halt;

    always_ff @(posedge CLK) begin
        if (reset) state <= ACCEPT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCEPT: if (cmd_valid && cmd_ready) next_state = COMMIT;
            COMMIT: next_state = ACCEPT;
            default: next_state = ACCEPT;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        case (state)
            ACCEPT:  cmd_ready = halt && !buffer_full;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Slot data lands one cycle before its stepready toggle, so the timer never sees unstable data.
    always_ff @(posedge CLK) begin
        if (accept) begin
            slot_duration[writemoveind]  <= cmd_duration;
            slot_increment[writemoveind] <= cmd_increment;
            slot_incinc[writemoveind]    <= cmd_incrementincrement;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stepready    <= '0;
            writemoveind <= '0;
            move_count   <= '0;
        end else if (commit) begin
            stepready[writemoveind] <= ~stepready[writemoveind];
            writemoveind            <= writemoveind + IDX_BITS'(1);
            move_count              <= move_count + 32'd1;
        end
    end

    assign move_duration      = slot_duration[moveind];
    assign increment          = slot_increment[moveind];
    assign incrementincrement = slot_incinc[moveind];

endmodule
